axi_rd_firewall: RTL and testbench

AXI_RD_FIREWALL -- requirements
Module: axi_rd_firewall

---
 rtl/axi_rd_firewall.sv | 117 +++++++++++
 tb/tb_axi_rd_firewall.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_firewall.sv
// AXI read-channel firewall: blocks reads that fall inside a protected window on
// address bits [27:0], answering them locally with SLVERR and logging the violation.
module axi_rd_firewall #(
   parameter logic [27:0] RD_PROT_START = 28'h0001000,
   parameter logic [27:0] RD_PROT_END   = 28'h0002000
) (
   input  logic        S_AXI_ACLK,
   input  logic        S_AXI_ARESETN,
   input  logic [31:0] S_ARADDR,
   input  logic        S_ARVALID,
   output logic        S_ARREADY,
   output logic [31:0] S_RDATA,
   output logic [1:0]  S_RRESP,
   output logic        S_RVALID,
   input  logic        S_RREADY,
   output logic [31:0] M_ARADDR,
   output logic        M_ARVALID,
   input  logic        M_ARREADY,
   input  logic [31:0] M_RDATA,
   input  logic [1:0]  M_RRESP,
   input  logic        M_RVALID,
   output logic        M_RREADY,
   output logic [15:0] VIOL_CNT,
   output logic [31:0] VIOL_ADDR,
   output logic        VIOL_IRQ,
   input  logic        IRQ_CLR
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;
   localparam int unsigned WW = 28;

   typedef enum logic [1:0] {IDLE, FWD_AR, WAIT_R, ERR_R} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q;
   logic [CW-1:0]   viol_cnt_q;
   logic [AW-1:0]   viol_addr_q;
   logic            viol_irq_q;
   logic            accept_c;
   logic            in_window_c;
   logic            block_c;

   // The value tested here is the one captured into addr_q on the same edge.
   assign accept_c    = (state_q == IDLE) && S_ARVALID;
   assign in_window_c = (S_ARADDR[WW-1:0] >= RD_PROT_START) && (S_ARADDR[WW-1:0] < RD_PROT_END);
   assign block_c     = accept_c && in_window_c;

   // State and captured request address.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q <= IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept_c) addr_q <= S_ARADDR;
      end
   end

   // Next state and channel outputs decoded from the current state.
   always_comb begin
      state_d   = state_q;
      S_ARREADY = 1'b0;
      M_ARVALID = 1'b0;
      S_RVALID  = 1'b0;
      S_RDATA   = '0;
      S_RRESP   = '0;
      M_RREADY  = 1'b0;
      case (state_q)
         IDLE: begin
            S_ARREADY = 1'b1;
            if (S_ARVALID) state_d = in_window_c ? ERR_R : FWD_AR;
         end
         FWD_AR: begin
            M_ARVALID = 1'b1;
            if (M_ARREADY) state_d = WAIT_R;
         end
         WAIT_R: begin
            S_RVALID = M_RVALID;
            S_RDATA  = M_RDATA;
            S_RRESP  = M_RRESP;
            M_RREADY = S_RREADY;
            if (M_RVALID && S_RREADY) state_d = IDLE;
         end
         ERR_R: begin
            S_RVALID = 1'b1;
            S_RDATA  = DW'(0);
            S_RRESP  = 2'b10;
            if (S_RREADY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign M_ARADDR = addr_q;

   // Violation log; a new violation wins over a simultaneous clear.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         viol_cnt_q  <= '0;
         viol_addr_q <= '0;
         viol_irq_q  <= 1'b0;
      end else if (block_c) begin
         if (viol_cnt_q != '1) viol_cnt_q <= viol_cnt_q + CW'(1);
         viol_addr_q <= S_ARADDR;
         viol_irq_q  <= 1'b1;
      end else if (IRQ_CLR) begin
         viol_irq_q  <= 1'b0;
      end
   end

   assign VIOL_CNT  = viol_cnt_q;
   assign VIOL_ADDR = viol_addr_q;
   assign VIOL_IRQ  = viol_irq_q;

endmodule

// File: tb/tb_axi_rd_firewall.sv
// Self-checking bench for axi_rd_firewall: directed vector table, hand sequences
// for multi-cycle corners, and randomized reads against a window/log model.
module tb_axi_rd_firewall;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] S_ARADDR;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RVALID;
   logic        S_RREADY;
   logic [31:0] M_ARADDR;
   logic        M_ARVALID;
   logic        M_ARREADY;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RVALID;
   logic        M_RREADY;
   logic [15:0] VIOL_CNT;
   logic [31:0] VIOL_ADDR;
   logic        VIOL_IRQ;
   logic        IRQ_CLR;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cur_addr = '0;

   // Reference log state
   logic [15:0] m_cnt   = '0;
   logic [31:0] m_vaddr = '0;
   logic        m_irq   = 1'b0;

   typedef struct {
      logic [31:0] addr;
      bit          blk;
      int          arw;
      int          rw;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   axi_rd_firewall dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_ARADDR      (S_ARADDR),
      .S_ARVALID     (S_ARVALID),
      .S_ARREADY     (S_ARREADY),
      .S_RDATA       (S_RDATA),
      .S_RRESP       (S_RRESP),
      .S_RVALID      (S_RVALID),
      .S_RREADY      (S_RREADY),
      .M_ARADDR      (M_ARADDR),
      .M_ARVALID     (M_ARVALID),
      .M_ARREADY     (M_ARREADY),
      .M_RDATA       (M_RDATA),
      .M_RRESP       (M_RRESP),
      .M_RVALID      (M_RVALID),
      .M_RREADY      (M_RREADY),
      .VIOL_CNT      (VIOL_CNT),
      .VIOL_ADDR     (VIOL_ADDR),
      .VIOL_IRQ      (VIOL_IRQ),
      .IRQ_CLR       (IRQ_CLR)
   );

   function automatic bit in_window(input logic [31:0] a);
      int unsigned low;
      low = int'(a & 32'h0FFF_FFFF);
      return (low >= 32'h1000) && (low < 32'h2000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s addr=%h actual=%h required=%h", name, cur_addr, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_accept(input logic [31:0] a, input bit blk, input bit clr);
      if (blk) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         m_vaddr = a;
         m_irq   = 1'b1;
      end else if (clr) begin
         m_irq = 1'b0;
      end
   endtask

   task automatic check_log();
      chk("viol_cnt",  32'(VIOL_CNT), 32'(m_cnt));
      chk("viol_addr", VIOL_ADDR, m_vaddr);
      chk("viol_irq",  32'(VIOL_IRQ), 32'(m_irq));
   endtask

   // One complete read; starts and ends just after a falling edge in IDLE.
   task automatic txn(input logic [31:0] addr, input bit blk, input int ar_wait, input int r_wait,
                      input logic [31:0] data, input logic [1:0] resp, input bit clr);
      cur_addr = addr;
      chk("idle_s_arready", 32'(S_ARREADY), 32'd1);
      chk("idle_m_arvalid", 32'(M_ARVALID), 32'd0);
      S_ARVALID = 1'b1;
      S_ARADDR  = addr;
      IRQ_CLR   = clr;
      cyc();
      S_ARVALID = 1'b0;
      IRQ_CLR   = 1'b0;
      S_ARADDR  = $urandom;
      model_accept(addr, blk, clr);
      if (blk) begin
         for (int i = 0; i <= r_wait; i++) begin
            if (i > 0) cyc();
            chk("err_m_arvalid", 32'(M_ARVALID), 32'd0);
            chk("err_s_rvalid",  32'(S_RVALID), 32'd1);
            chk("err_s_rresp",   32'(S_RRESP), 32'd2);
            chk("err_s_rdata",   S_RDATA, 32'd0);
            chk("err_s_arready", 32'(S_ARREADY), 32'd0);
            chk("err_m_rready",  32'(M_RREADY), 32'd0);
         end
         S_RREADY = 1'b1;
         cyc();
         S_RREADY = 1'b0;
      end else begin
         for (int i = 0; i <= ar_wait; i++) begin
            if (i > 0) cyc();
            chk("fwd_m_arvalid", 32'(M_ARVALID), 32'd1);
            chk("fwd_m_araddr",  M_ARADDR, addr);
            chk("fwd_s_arready", 32'(S_ARREADY), 32'd0);
            chk("fwd_s_rvalid",  32'(S_RVALID), 32'd0);
         end
         M_ARREADY = 1'b1;
         cyc();
         M_ARREADY = 1'b0;
         chk("wait_m_arvalid", 32'(M_ARVALID), 32'd0);
         M_RVALID = 1'b1;
         M_RDATA  = data;
         M_RRESP  = resp;
         #1;
         for (int i = 0; i <= r_wait; i++) begin
            if (i > 0) begin cyc(); #1; end
            chk("wait_s_rvalid",  32'(S_RVALID), 32'd1);
            chk("wait_s_rdata",   S_RDATA, data);
            chk("wait_s_rresp",   32'(S_RRESP), 32'(resp));
            chk("wait_m_rready",  32'(M_RREADY), 32'd0);
            chk("wait_s_arready", 32'(S_ARREADY), 32'd0);
         end
         S_RREADY = 1'b1;
         #1;
         chk("wait_m_rready_hi", 32'(M_RREADY), 32'd1);
         cyc();
         S_RREADY = 1'b0;
         M_RVALID = 1'b0;
         M_RDATA  = '0;
         M_RRESP  = '0;
      end
      #1;
      chk("done_s_arready", 32'(S_ARREADY), 32'd1);
      chk("done_s_rvalid",  32'(S_RVALID), 32'd0);
      chk("done_m_arvalid", 32'(M_ARVALID), 32'd0);
      check_log();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      bit          b;

      vecs[0] = '{32'h0000_0FFF, 1'b0, 0, 0};
      vecs[1] = '{32'h0000_2000, 1'b0, 1, 2};
      vecs[2] = '{32'h0000_1000, 1'b1, 0, 0};
      vecs[3] = '{32'h0000_1FFF, 1'b1, 0, 1};
      vecs[4] = '{32'hF000_1000, 1'b1, 0, 2};
      vecs[5] = '{32'h0FFF_FFFF, 1'b0, 2, 0};
      vecs[6] = '{32'h1000_1FFF, 1'b1, 0, 0};
      vecs[7] = '{32'hA000_0000, 1'b0, 0, 1};

      rst_n = 1'b0;
      S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0; M_ARREADY = 1'b0;
      M_RDATA = '0; M_RRESP = '0; M_RVALID = 1'b0; IRQ_CLR = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_m_arvalid", 32'(M_ARVALID), 32'd0);
      chk("rst_s_rvalid",  32'(S_RVALID), 32'd0);
      chk("rst_m_rready",  32'(M_RREADY), 32'd0);
      chk("rst_m_araddr",  M_ARADDR, 32'd0);
      check_log();
      rst_n = 1'b1;
      #1;
      chk("rst_s_arready", 32'(S_ARREADY), 32'd1);

      // Basic forwarded and blocked reads
      txn(32'h0000_0500, 1'b0, 0, 0, 32'hCAFE_F00D, 2'b00, 1'b0);
      txn(32'h0000_1800, 1'b1, 0, 0, 32'h0, 2'b00, 1'b0);

      // Window boundaries and upper-nibble aliasing
      for (int i = 0; i < 8; i++)
         txn(vecs[i].addr, vecs[i].blk, vecs[i].arw, vecs[i].rw, 32'h1234_0000 + 32'(i), 2'(i), 1'b0);

      // Backpressure on both memory AR and initiator R
      txn(32'h0000_3000, 1'b0, 5, 3, 32'h5A5A_A5A5, 2'b01, 1'b0);

      // Clear on a forwarded read, then clear coinciding with a violation
      txn(32'h0000_0040, 1'b0, 0, 0, 32'h0000_0001, 2'b00, 1'b1);
      txn(32'h0000_1004, 1'b1, 0, 0, 32'h0, 2'b00, 1'b1);

      // New request held off during ERR_R, accepted in the first IDLE cycle
      cur_addr = 32'h0000_1234;
      S_ARVALID = 1'b1; S_ARADDR = 32'h0000_1234;
      cyc();
      model_accept(32'h0000_1234, 1'b1, 1'b0);
      S_ARADDR = 32'h0000_0700;
      for (int i = 0; i < 2; i++) begin
         chk("hold_s_arready", 32'(S_ARREADY), 32'd0);
         chk("hold_m_arvalid", 32'(M_ARVALID), 32'd0);
         cyc();
      end
      S_RREADY = 1'b1;
      cyc();
      S_RREADY = 1'b0;
      #1;
      chk("hold_idle_ready", 32'(S_ARREADY), 32'd1);
      cyc();
      S_ARVALID = 1'b0;
      cur_addr = 32'h0000_0700;
      chk("hold_m_arvalid2", 32'(M_ARVALID), 32'd1);
      chk("hold_m_araddr",   M_ARADDR, 32'h0000_0700);
      M_ARREADY = 1'b1;
      cyc();
      M_ARREADY = 1'b0;
      M_RVALID = 1'b1; M_RDATA = 32'h0BAD_CAFE; S_RREADY = 1'b1;
      #1;
      chk("hold_s_rdata", S_RDATA, 32'h0BAD_CAFE);
      cyc();
      M_RVALID = 1'b0; M_RDATA = '0; S_RREADY = 1'b0;
      #1;
      chk("hold_done_ready", 32'(S_ARREADY), 32'd1);
      check_log();

      // Saturation of the violation counter
      force dut.viol_cnt_q = 16'hFFFE;
      #1;
      release dut.viol_cnt_q;
      m_cnt = 16'hFFFE;
      chk("sat_preload", 32'(VIOL_CNT), 32'h0000_FFFE);
      for (int i = 0; i < 3; i++)
         txn(32'h0000_1100 + 32'(i * 4), 1'b1, 0, 0, 32'h0, 2'b00, 1'(i == 1));

      // Randomized reads
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[27:0] = 28'($urandom_range(0, 32'h3FFF));
         b = in_window(a);
         txn(a, b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      end

      // Asynchronous reset while waiting on the memory R channel
      cur_addr = 32'h0000_4444;
      S_ARVALID = 1'b1; S_ARADDR = 32'h0000_4444;
      cyc();
      S_ARVALID = 1'b0;
      M_ARREADY = 1'b1;
      cyc();
      M_ARREADY = 1'b0;
      M_RVALID = 1'b1; M_RDATA = 32'hDEAD_BEEF;
      #1;
      chk("prerst_s_rvalid", 32'(S_RVALID), 32'd1);
      #2;
      rst_n = 1'b0; S_RREADY = 1'b1;
      #1;
      chk("arst_s_rvalid",  32'(S_RVALID), 32'd0);
      chk("arst_s_rdata",   S_RDATA, 32'd0);
      chk("arst_m_rready",  32'(M_RREADY), 32'd0);
      chk("arst_m_arvalid", 32'(M_ARVALID), 32'd0);
      chk("arst_m_araddr",  M_ARADDR, 32'd0);
      m_cnt = '0; m_vaddr = '0; m_irq = 1'b0;
      check_log();
      M_RVALID = 1'b0; M_RDATA = '0; S_RREADY = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      txn(32'h0000_0500, 1'b0, 0, 0, 32'hCAFE_F00D, 2'b00, 1'b0);
      txn(32'h0000_1800, 1'b1, 0, 0, 32'h0, 2'b00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
